// File: rtl/groestl_pkg.sv
// Shared constants, types and GF(2^8) helpers for the Groestl-256 core.
package groestl_pkg;

  localparam int STATE           = 512;
  localparam int WORD            = 16;
  localparam int WORDS_PER_BLOCK = 32;
  localparam int DIGEST_WORDS    = 16;
  localparam int ROUNDS          = 10;

  // Chaining value at message start: 64-bit big-endian 256 in the last 8 bytes.
  localparam logic [STATE-1:0] IV = {{(STATE-16){1'b0}}, 16'h0100};

  // Left-rotation amount per row for the Q permutation.
  localparam logic [2:0] Q_SHIFT [8] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};

  // First row of the circulant MixBytes matrix.
  localparam logic [7:0] MIX_ROW [8] = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMPRESS = 2'd1,
    S_OUTPUT   = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by one of the small MixBytes coefficients.
  function automatic logic [7:0] gf_mulc(input logic [7:0] c, input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = gf_mul2(a);
    x4 = gf_mul2(x2);
    case (c)
      8'h02:   return x2;
      8'h03:   return x2 ^ a;
      8'h04:   return x4;
      8'h05:   return x4 ^ a;
      8'h07:   return x4 ^ x2 ^ a;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/groestl_round.sv
// One combinational round of the Groestl P or Q permutation.
// Byte k of the state sits at row k%8, column k/8, big-endian in the vector.
module groestl_round
  import groestl_pkg::*;
(
  input  logic [STATE-1:0] i_state,
  input  logic [3:0]       i_round,
  input  logic             i_q,
  output logic [STATE-1:0] o_state
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction

  // Bit offset of the byte at (row, col).
  function automatic int boff(input int row, input int col);
    return STATE - 8 - 8*(8*col + row);
  endfunction

  logic [STATE-1:0] w_sub;
  logic [STATE-1:0] w_shift;

  // Round-constant addition followed by the S-box on every byte.
  always_comb begin
    logic [7:0] w_byte;
    w_sub  = '0;
    w_byte = 8'h00;
    for (int col = 0; col < 8; col++) begin
      for (int row = 0; row < 8; row++) begin
        w_byte = i_state[boff(row, col) +: 8];
        if (i_q) begin
          w_byte = w_byte ^ 8'hFF;
          if (row == 7) w_byte = w_byte ^ {4'(col), i_round};
          else          w_byte = w_byte;
        end else begin
          if (row == 0) w_byte = w_byte ^ {4'(col), i_round};
          else          w_byte = w_byte;
        end
        w_sub[boff(row, col) +: 8] = sbox(w_byte);
      end
    end
  end

  // Row rotation: P rotates row i by i, Q uses its own table.
  always_comb begin
    int w_sh;
    w_shift = '0;
    w_sh    = 0;
    for (int row = 0; row < 8; row++) begin
      if (i_q) w_sh = int'(Q_SHIFT[row]);
      else     w_sh = row;
      for (int col = 0; col < 8; col++) begin
        w_shift[boff(row, col) +: 8] = w_sub[boff(row, (col + w_sh) % 8) +: 8];
      end
    end
  end

  // Column mixing by the circulant matrix over GF(2^8).
  always_comb begin
    logic [7:0] w_acc;
    o_state = '0;
    w_acc   = 8'h00;
    for (int col = 0; col < 8; col++) begin
      for (int row = 0; row < 8; row++) begin
        w_acc = 8'h00;
        for (int k = 0; k < 8; k++) begin
          w_acc = w_acc ^ gf_mulc(MIX_ROW[(k - row + 8) % 8], w_shift[boff(k, col) +: 8]);
        end
        o_state[boff(row, col) +: 8] = w_acc;
      end
    end
  end

endmodule

// File: rtl/groestl_top.sv
// Groestl-256 core with a 16-bit word-serial load/fetch host interface.
module groestl_top
  import groestl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init,
  input  logic            load,
  input  logic            fetch,
  input  logic [WORD-1:0] idata,
  output logic            ack,
  output logic [WORD-1:0] odata
);

  state_e           r_state;
  state_e           w_next;
  logic [STATE-1:0] r_h;
  logic [STATE-1:0] r_m;
  logic [STATE-1:0] r_p;
  logic [STATE-1:0] r_q;
  logic [3:0]       r_round;
  logic [4:0]       r_wcnt;
  logic [3:0]       r_fcnt;
  logic             r_final;
  logic             r_ack;
  logic [WORD-1:0]  r_odata;

  logic             w_load_acc;
  logic             w_fetch_acc;
  logic             w_last;
  logic [STATE-1:0] w_p_in;
  logic [STATE-1:0] w_q_in;
  logic [STATE-1:0] w_p_out;
  logic [STATE-1:0] w_q_out;

  assign w_last = (r_round == 4'(ROUNDS - 1));
  assign ack    = r_ack;
  assign odata  = r_odata;

  // Round 0 takes its inputs straight from h and m; later rounds iterate on p/q.
  always_comb begin
    w_p_in = r_p;
    w_q_in = r_q;
    if (r_round == 4'd0) begin
      w_q_in = r_m;
      if (r_state == S_COMPRESS) w_p_in = r_h ^ r_m;
      else                       w_p_in = r_h;
    end else begin
      w_p_in = r_p;
      w_q_in = r_q;
    end
  end

  groestl_round u_round_p (
    .i_state (w_p_in),
    .i_round (r_round),
    .i_q     (1'b0),
    .o_state (w_p_out)
  );

  groestl_round u_round_q (
    .i_state (w_q_in),
    .i_round (r_round),
    .i_q     (1'b1),
    .o_state (w_q_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and transfer acceptance; a load wins over a simultaneous fetch.
  always_comb begin
    w_next      = r_state;
    w_load_acc  = 1'b0;
    w_fetch_acc = 1'b0;
    if (init) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            if (!r_final) begin
              w_load_acc = 1'b1;
              if (r_wcnt == 5'(WORDS_PER_BLOCK - 1)) w_next = S_COMPRESS;
              else                                   w_next = S_IDLE;
            end else begin
              w_next = S_IDLE;
            end
          end else if (fetch && !r_final && (r_wcnt == 5'd0)) begin
            w_next = S_OUTPUT;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_COMPRESS: begin
          if (w_last) w_next = S_IDLE;
          else        w_next = S_COMPRESS;
        end
        S_OUTPUT: begin
          if (w_last) w_next = S_DONE;
          else        w_next = S_OUTPUT;
        end
        S_DONE: begin
          w_next = S_DONE;
          if (fetch) w_fetch_acc = 1'b1;
          else       w_fetch_acc = 1'b0;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: message buffer, permutation state, chaining value, counters, ack/odata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h     <= IV;
      r_m     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_round <= 4'd0;
      r_wcnt  <= 5'd0;
      r_fcnt  <= 4'd0;
      r_final <= 1'b0;
      r_ack   <= 1'b0;
      r_odata <= '0;
    end else if (init) begin
      r_h     <= IV;
      r_round <= 4'd0;
      r_wcnt  <= 5'd0;
      r_fcnt  <= 4'd0;
      r_final <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_load_acc | w_fetch_acc;
      if (w_load_acc) begin
        r_m[(WORDS_PER_BLOCK - 1 - int'(r_wcnt))*WORD +: WORD] <= idata;
        r_wcnt <= r_wcnt + 5'd1;
      end
      if (w_fetch_acc) begin
        r_odata <= r_h[(DIGEST_WORDS - 1 - int'(r_fcnt))*WORD +: WORD];
        r_fcnt  <= r_fcnt + 4'd1;
      end
      if ((r_state == S_COMPRESS) || (r_state == S_OUTPUT)) begin
        r_p <= w_p_out;
        r_q <= w_q_out;
        if (w_last) begin
          r_round <= 4'd0;
          if (r_state == S_COMPRESS) begin
            r_h <= w_p_out ^ w_q_out ^ r_h;
          end else begin
            r_h     <= w_p_out ^ r_h;
            r_final <= 1'b1;
          end
        end else begin
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_groestl_top.sv
// Directed self-checking bench for groestl_top using the empty-message vector.
module tb_groestl_top;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        init  = 1'b0;
  logic        load  = 1'b0;
  logic        fetch = 1'b0;
  logic [15:0] idata = 16'h0000;
  logic        ack;
  logic [15:0] odata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] data;
    logic        exp_ack;
  } load_vec_t;

  load_vec_t   ld_tab [32];
  logic [15:0] dig_tab [16];

  groestl_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .load  (load),
    .fetch (fetch),
    .idata (idata),
    .ack   (ack),
    .odata (odata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    check("init_no_ack", {31'd0, ack}, 32'd0);
  endtask

  // Stream the padded empty block with load held; optionally keep load up with another word.
  task automatic load_block(input bit keep_load, input logic [15:0] next_word);
    load = 1'b1;
    for (int w = 0; w < 32; w++) begin
      idata = ld_tab[w].data;
      tick();
      check($sformatf("load_ack[%0d]", w), {31'd0, ack}, {31'd0, ld_tab[w].exp_ack});
    end
    if (keep_load) begin
      idata = next_word;
    end else begin
      load = 1'b0;
    end
  endtask

  // Fetch nwords digest words starting at table index first, with a bounded wait per word.
  task automatic fetch_words(input int nwords, input int first, input bit check_vals);
    int wait_n;
    fetch = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      wait_n = 0;
      do begin
        tick();
        wait_n++;
      end while ((ack !== 1'b1) && (wait_n < 32));
      check($sformatf("fetch_ack[%0d]", w), {31'd0, ack}, 32'd1);
      if (check_vals) begin
        check($sformatf("digest[%0d]", (first + w) % 16), {16'd0, odata},
              {16'd0, dig_tab[(first + w) % 16]});
      end
    end
    fetch = 1'b0;
  endtask

  initial begin
    int n_ack;

    for (int w = 0; w < 32; w++) begin
      ld_tab[w].data    = 16'h0000;
      ld_tab[w].exp_ack = 1'b1;
    end
    ld_tab[0].data  = 16'h8000;
    ld_tab[31].data = 16'h0001;
    dig_tab = '{16'h1a52, 16'hd11d, 16'h5500, 16'h39be, 16'h1610, 16'h7f9c, 16'h58db, 16'h9ebc,
                16'hc417, 16'hf16f, 16'h736a, 16'hdb25, 16'h0256, 16'h7119, 16'hf008, 16'h3467};

    // Reset values, then a fetch with no init must complete.
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_odata", {16'd0, odata}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset_ack", {31'd0, ack}, 32'd0);
    check("post_reset_odata", {16'd0, odata}, 32'd0);
    fetch_words(1, 0, 1'b0);

    // Empty message, full digest.
    do_init();
    load_block(1'b0, 16'h0000);
    fetch_words(16, 0, 1'b1);

    // Loads are ignored once the digest is final.
    load  = 1'b1;
    idata = 16'h1234;
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ack === 1'b1) n_ack++;
    end
    load = 1'b0;
    check("load_ignored_when_final", n_ack, 0);

    // Second message after init gives the same digest; 17th fetch wraps.
    do_init();
    load_block(1'b0, 16'h0000);
    fetch_words(16, 0, 1'b1);
    fetch_words(1, 16, 1'b1);

    // Stall: another load straight after word 31 waits out COMPRESS.
    do_init();
    load_block(1'b1, 16'h8000);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("stall_ack[%0d]", c), {31'd0, ack}, 32'd0);
    end
    tick();
    check("stall_accept", {31'd0, ack}, 32'd1);
    load = 1'b0;

    // Fetch with a partial block loaded stalls without ack.
    do_init();
    load  = 1'b1;
    idata = 16'h8000;
    tick();
    check("partial_load_ack", {31'd0, ack}, 32'd1);
    load  = 1'b0;
    fetch = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack === 1'b1) n_ack++;
    end
    fetch = 1'b0;
    check("partial_fetch_stalled", n_ack, 0);

    // Abort mid-COMPRESS, then a clean message.
    do_init();
    load_block(1'b0, 16'h0000);
    repeat (4) tick();
    do_init();
    load_block(1'b0, 16'h0000);
    fetch_words(16, 0, 1'b1);

    // Load and fetch held together: loads win, pending fetch then yields the digest.
    do_init();
    fetch = 1'b1;
    load_block(1'b0, 16'h0000);
    fetch_words(16, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
